// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, and the
// combinational round primitives (S-box, SubBytes, ShiftRows, MixColumns).
package aes_round_ctrl_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Byte i (column-major, i = 4*col + row) occupies [byte_msb(i) -: 8].
  function automatic int byte_msb(input int i);
    return 127 - 8 * i;
  endfunction

  function automatic logic [7:0] rcon_byte(input int rnd);
    logic [7:0] r;
    case (rnd)
      1:       r = 8'h01;
      2:       r = 8'h02;
      3:       r = 8'h04;
      4:       r = 8'h08;
      5:       r = 8'h10;
      6:       r = 8'h20;
      7:       r = 8'h40;
      8:       r = 8'h80;
      9:       r = 8'h1b;
      10:      r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[byte_msb(i) -: 8] = sbox(s[byte_msb(i) -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[byte_msb(4 * c + rw) -: 8] = s[byte_msb(4 * ((c + rw) % 4) + rw) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_msb(4 * c)     -: 8];
      a1 = s[byte_msb(4 * c + 1) -: 8];
      a2 = s[byte_msb(4 * c + 2) -: 8];
      a3 = s[byte_msb(4 * c + 3) -: 8];
      r[byte_msb(4 * c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[byte_msb(4 * c + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[byte_msb(4 * c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[byte_msb(4 * c + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_key_step.sv
// Combinational AES-128 key schedule step: next round key from the current
// round key and the round constant.
module aes_key_step
  import aes_round_ctrl_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  // SubWord(RotWord(w3)) through four S-boxes, then the round constant.
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock, on-the-fly
// key schedule, ciphertext held under a valid/ready handshake.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int RND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       plaintext,
  input  logic [127:0]       key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       ciphertext,
  output logic               busy,
  output logic [RND_W-1:0]   round
);

  localparam logic [RND_W-1:0] NR_R  = RND_W'(NR);
  localparam logic [RND_W-1:0] ONE_R = RND_W'(1);

  aes_state_e         state;
  logic [127:0]       state_reg;
  logic [127:0]       key_reg;
  logic [RND_W-1:0]   round_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [127:0]       nk;
  logic [127:0]       sr;
  logic [127:0]       mc;
  logic               accept;

  aes_key_step u_key_step (
    .key_in  (key_reg),
    .rcon    (rcon_byte(int'(round_q))),
    .key_out (nk)
  );

  assign sr = shift_rows(sub_bytes(state_reg));
  assign mc = mix_columns(sr);

  // in_ready is held low for the whole reset window, not just at the edge.
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      state_reg   <= '0;
      key_reg     <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            round_q   <= ONE_R;
            busy_q    <= 1'b1;
            state     <= ROUND;
          end
        end

        ROUND: begin
          key_reg <= nk;
          if (round_q < NR_R) begin
            state_reg <= mc ^ nk;
            round_q   <= round_q + ONE_R;
          end else begin
            state_reg   <= sr ^ nk;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // A pair offered on the handshake cycle starts straight away.
            if (in_valid) begin
              state_reg <= plaintext ^ key;
              key_reg   <= key;
              round_q   <= ONE_R;
              busy_q    <= 1'b1;
              state     <= ROUND;
            end else begin
              round_q <= '0;
              state   <= IDLE;
            end
          end
        end

        default: begin
          round_q     <= '0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign round      = round_q;
  assign ciphertext = out_valid_q ? state_reg : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: FIPS-197 vectors, random pairs,
// backpressure, back-to-back, asynchronous reset and input isolation.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;

  aes_round_ctrl #(.NR(10), .RND_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  bit           prev_ov   = 1'b0;
  bit           b2b_mode  = 1'b0;
  bit           rnd_ready = 1'b0;
  int           last_rise = -1;

  logic [7:0] sb[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][31 - 8 * r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rnd < 10)
            s[r][c] = mul(8'h02, t[r][c]) ^ mul(8'h03, t[(r + 1) % 4][c]) ^
                      t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: latency, round sequence, spacing and ciphertext at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (busy && acc_q.size() != 0)
        chk("round_seq", 128'(round), 128'(cyc - acc_q[0] + 1));
      if (out_valid && !prev_ov) begin
        if (acc_q.size() != 0) begin
          chk("latency", 128'(cyc - acc_q.pop_front()), 128'(10));
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
        end
        if (b2b_mode && last_rise >= 0)
          chk("b2b_spacing", 128'(cyc - last_rise), 128'(11));
        last_rise = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          chk("ciphertext", ciphertext, exp_q.pop_front());
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_handshake actual=%h required=none", ciphertext);
        end
        if (b2b_mode && in_valid)
          chk("b2b_in_ready", 128'(in_ready), 128'(1));
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input bit keep, input bit scramble);
    int t;
    t         = 0;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout actual=%0d required<300", t);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_encrypt(pt, k));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 9; i++) begin
        plaintext = rand128();
        key       = rand128();
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    build_sbox();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;

    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_ciphertext", ciphertext, 128'(0));
    chk("model_selftest_b", ref_encrypt(PT_B, KEY_B), CT_B);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("idle_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;

    // FIPS-197 Appendix B and C.1.
    send(PT_B, KEY_B, 1'b0, 1'b0);
    wait_done();
    send(PT_C, KEY_C, 1'b0, 1'b0);
    wait_done();

    // Backpressure: result held, new pair refused.
    out_ready = 1'b0;
    send(PT_C, KEY_C, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_reached_done", 128'(out_valid), 128'(1));
    chk("final_key_reg", dut.key_reg, RK10_C);
    in_valid  = 1'b1;
    plaintext = PT_B;
    key       = KEY_B;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_ciphertext", ciphertext, CT_C);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_no_accept", 128'(busy), 128'(0));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();

    // Back-to-back with in_valid held high.
    b2b_mode  = 1'b1;
    last_rise = -1;
    send(PT_C, KEY_C, 1'b1, 1'b0);
    send(PT_B, KEY_B, 1'b0, 1'b0);
    wait_done();
    b2b_mode = 1'b0;

    // Asynchronous reset in round 5.
    send(PT_C, KEY_C, 1'b0, 1'b0);
    t = 0;
    while (round != 4'd5 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_round5", 128'(round), 128'(5));
    #3 rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_round", 128'(round), 128'(0));
    chk("abort_ciphertext", ciphertext, 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    send(PT_C, KEY_C, 1'b0, 1'b0);
    wait_done();

    // Random pairs with inputs scrambled mid-run and random out_ready.
    rnd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(rand128(), rand128(), 1'b0, 1'b1);
      wait_done();
    end
    rnd_ready = 1'b0;

    repeat (3) @(posedge clk);
    chk("final_idle_out_valid", 128'(out_valid), 128'(0));
    chk("final_scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer: accepts one plaintext/key pair and runs the SubBytes → ShiftRows → MixColumns → AddRoundKey round datapath once per clock for 10 rounds.
- Round keys are generated on the fly, and the ciphertext is held under a valid/ready handshake.
- Sits between the host/bus interface and the existing combinational round blocks; it is the only state-holding element of the encryption core.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- RND_W, 4, width of the round counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  block can accept a new pair
- plaintext  input  128  state input; bits [127:120] = byte 0, column-major (row r, col c at bits 127-8*(4c+r))
- key  input  128  cipher key, same byte ordering
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result, same byte ordering
- busy  output  1  high in ROUND state
- round  output  RND_W  current round index (debug/trojan-monitor tap)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, state_reg=0, key_reg=0, round=0.
  - in_ready=0 while rst is high, then 1 in the first IDLE cycle.
  - out_valid=0, ciphertext=0, busy=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg<=plaintext^key, key_reg<=key, round<=1, go to ROUND.
- ROUND (busy=1, in_ready=0) each cycle:
  - nk = key_step(key_reg, rcon[round]).
  - If round<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg)))^nk; key_reg<=nk; round<=round+1.
  - If round==NR: state_reg <= ShiftRows(SubBytes(state_reg))^nk (no MixColumns); go to DONE.
- DONE:
  - out_valid=1; ciphertext=state_reg, stable until handshake.
  - On out_ready: out_valid drops next cycle and the block returns to IDLE.
  - in_ready = out_ready in DONE. A new pair offered in the same cycle as the output handshake is accepted directly (DONE→ROUND), giving back-to-back throughput of one block per 11 cycles.
- Latency: accept edge at cycle 0 → out_valid high at cycle 10, i.e. after NR ROUND cycles.
- rcon table: rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- key_step:
  - w3' = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^w3', w1' = w1^w0', w2' = w2^w1', w3'' = w3^w2'.
  - w0 = key_reg[127:96].
- plaintext/key changes while not in IDLE (or DONE with out_ready) are ignored.
- in_valid with out_ready low in DONE: held off, no accept.
- round never exceeds NR; if an illegal state is decoded, go to IDLE.
- rst asserted mid-operation: immediate abort, all outputs to reset values, no partial ciphertext emitted.
- out_ready asserted while out_valid=0: no effect.

Decomposition:
- Shared package/header aes_pkg:
  - state encodings (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
  - NR
  - rcon function/table
  - 128-bit byte-index helper macro
- Reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey instances.
- One new sub-module, aes_key_step: combinational next-round-key from (key_in, rcon). It instantiates four S-boxes via the existing S-box.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept, round sequence 1..10.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: ct 69c4e0d86a7b0430d8cdb78070b4c55a. Final key_reg equals 13111d7fe3944a17f307a78b4d2b30c5.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after completion.
  - Response: out_valid and ciphertext stay stable, in_ready=0, and a new in_valid is not accepted.
- Back-to-back:
  - Stimulus: in_valid=1 continuously with vector C.1 then B, out_ready=1.
  - Response: second accept in the same cycle as the first output handshake; two correct ciphertexts 11 cycles apart.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously at round 5.
  - Response: out_valid, busy, round and ciphertext go to 0 without waiting for a clock; after release, in_ready=1 and a fresh C.1 run still gives 69c4e0d8…
- Input isolation:
  - Stimulus: toggle plaintext/key randomly during ROUND.
  - Response: ciphertext is unchanged from the expected value.
